// File: rtl/wm8731_pkg.sv
// wm8731_pkg: shared constants, init words and FSM types for the WM8731 config sequencer
package wm8731_pkg;
    localparam logic [6:0] CODEC_ADDR_DEFAULT = 7'b0011010;
    localparam int N_INIT = 7;
    localparam logic [15:0] INIT_RESET    = 16'h1E00;
    localparam logic [15:0] INIT_ANALOG   = 16'h0815;
    localparam logic [15:0] INIT_DIGITAL  = 16'h0A00;
    localparam logic [15:0] INIT_POWER    = 16'h0C00;
    localparam logic [15:0] INIT_FORMAT   = 16'h0E42;
    localparam logic [15:0] INIT_SAMPLING = 16'h1019;
    localparam logic [15:0] INIT_ACTIVE   = 16'h1201;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} seq_state_t;
    typedef enum logic {MODE_INIT, MODE_USER} seq_mode_t;
endpackage

// File: rtl/wm8731_cmd_rom.sv
// wm8731_cmd_rom: combinational init-table lookup, index -> 16-bit codec word
module wm8731_cmd_rom
    import wm8731_pkg::*;
(
    input  logic [2:0]  i_idx,
    output logic [15:0] o_word
);
    always_comb begin
        case (i_idx)
            3'd0:    o_word = INIT_RESET;
            3'd1:    o_word = INIT_ANALOG;
            3'd2:    o_word = INIT_DIGITAL;
            3'd3:    o_word = INIT_POWER;
            3'd4:    o_word = INIT_FORMAT;
            3'd5:    o_word = INIT_SAMPLING;
            3'd6:    o_word = INIT_ACTIVE;
            default: o_word = '0;
        endcase
    end
endmodule

// File: rtl/wm8731_config_seq.sv
// wm8731_config_seq: drives the I2C master through the codec init table, then serves runtime user writes
module wm8731_config_seq
    import wm8731_pkg::*;
#(
    parameter logic [6:0] CODEC_ADDR     = CODEC_ADDR_DEFAULT,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_user_req,
    input  logic [15:0] i_user_data,
    output logic        o_user_ack,
    output logic        o_i2c_start,
    output logic [6:0]  o_i2c_addr,
    output logic        o_i2c_rw,
    output logic [15:0] o_i2c_reg_data,
    input  logic        i_i2c_finished,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_error
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t  state_q, state_d;
    seq_mode_t   mode_q, mode_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d, rom_word;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic        done_q, done_d, err_q, err_d, ack_q, ack_d;
    logic        fin_q, fin_prev_q, rise;

    wm8731_cmd_rom u_rom (.i_idx(idx_d), .o_word(rom_word));

    // completion is a rising edge of the registered flag, so a level left high from a prior write is ignored
    assign rise = fin_q & ~fin_prev_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        done_d  = done_q;
        err_d   = err_q;
        ack_d   = 1'b0;
        gap_d   = state_q == GAP ? gap_q + GW'(1) : '0;
        to_d    = state_q == WAIT ? to_q + TW'(1) : '0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ISSUE;
                    mode_d  = MODE_INIT;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (i_user_req && done_q) begin
                    state_d = ISSUE;
                    mode_d  = MODE_USER;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (rise) begin
                    state_d = GAP;
                end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    ack_d   = mode_q == MODE_USER;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (mode_q == MODE_USER) begin
                        state_d = IDLE;
                        ack_d   = 1'b1;
                    end else if (idx_q == 3'(N_INIT - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
        endcase
        word_d = (state_d == ISSUE && state_q != ISSUE) ? (mode_d == MODE_USER ? i_user_data : rom_word) : word_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_INIT;
            idx_q      <= '0;
            word_q     <= '0;
            gap_q      <= '0;
            to_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            fin_q      <= 1'b0;
            fin_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            fin_q      <= i_i2c_finished;
            fin_prev_q <= fin_q;
        end
    end

    assign o_i2c_start    = state_q == ISSUE;
    assign o_i2c_addr     = CODEC_ADDR;
    assign o_i2c_rw       = 1'b0;
    assign o_i2c_reg_data = word_q;
    assign o_busy         = state_q != IDLE;
    assign o_init_done    = done_q;
    assign o_error        = err_q;
    assign o_user_ack     = ack_q;
endmodule

// File: tb/tb_wm8731_config_seq.sv
// tb_wm8731_config_seq: scoreboard bench with an I2C master model (configurable finish delay, hang-on-word mode)
module tb_wm8731_config_seq;
    localparam int GAP = 16;
    localparam int TO  = 300;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, req = 1'b0, fin = 1'b0;
    logic [15:0] udata = '0;
    logic        ack, i2c_start, rw, busy, done, err;
    logic [6:0]  addr;
    logic [15:0] reg_data;

    wm8731_config_seq #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_user_req(req), .i_user_data(udata),
        .o_user_ack(ack), .o_i2c_start(i2c_start), .o_i2c_addr(addr), .o_i2c_rw(rw),
        .o_i2c_reg_data(reg_data), .i_i2c_finished(fin), .o_busy(busy),
        .o_init_done(done), .o_error(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0, starts = 0, acks = 0, last_rise = -1, last_start = 0;
    int model_n = 50, mcnt = 0;
    logic [15:0] hang_word = 16'hFFFF;
    logic pend = 1'b0, prev_fin = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] init_words[7] = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // I2C master model: drops finished on start, raises it model_n cycles later unless hanging on this word
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fin  <= 1'b0;
            pend <= 1'b0;
            mcnt <= 0;
        end else if (i2c_start) begin
            fin  <= 1'b0;
            pend <= reg_data != hang_word;
            mcnt <= model_n;
        end else if (pend) begin
            if (mcnt <= 1) begin
                fin  <= 1'b1;
                pend <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (i2c_start) begin
            starts++;
            last_start = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_start: got %0h expected none", reg_data);
            end else begin
                check("start_word", reg_data, exp_q.pop_front());
            end
            check("start_rw", rw, 0);
            if (last_rise >= 0) begin
                n_checks++;
                if (cyc - last_rise < GAP) begin
                    n_fail++;
                    $display("FAIL gap: got %0d cycles required >= %0d", cyc - last_rise, GAP);
                end
            end
        end
        if (ack) acks++;
        if (fin && !prev_fin) last_rise = cyc;
        prev_fin = fin;
    end

    task automatic push_init(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(init_words[i]);
    endtask

    task automatic pulse_start(input logic expect_issue, input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(name, i2c_start, expect_issue);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        repeat (2) @(negedge clk);
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, busy, 0);
    endtask

    task automatic wait_ack(input int budget, input string name);
        int i = 0;
        while (!ack && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, ack, 1);
        req = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int i = 0;
        while (starts < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, starts >= target, 1);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_start"}, i2c_start, 0);
        check({name, "_data"}, reg_data, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_ack"}, ack, 0);
        check({name, "_addr"}, addr, 7'h1A);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, i, d;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst = 1'b0;

        // 1) full init sequence
        push_init(7);
        s0 = starts;
        pulse_start(1, "start_latency");
        wait_idle(2000, "init1_idle");
        check("init1_done", done, 1);
        check("init1_starts", starts - s0, 7);
        check("init1_queue", exp_q.size(), 0);

        // 2) runtime user write after init
        exp_q.push_back(16'h0479);
        a0 = acks;
        udata = 16'h0479;
        req = 1'b1;
        wait_ack(500, "user_ack");
        @(negedge clk);
        check("user_ack_count", acks - a0, 1);
        check("user_ack_pulse", ack, 0);
        check("user_done_kept", done, 1);

        // 3) user request before init is held off, then served after init
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rerst_done", done, 0);
        s0 = starts;
        a0 = acks;
        udata = 16'h0479;
        req = 1'b1;
        repeat (30) @(negedge clk);
        check("held_no_start", starts - s0, 0);
        check("held_no_ack", acks - a0, 0);
        push_init(7);
        exp_q.push_back(16'h0479);
        pulse_start(1, "pend_start");
        wait_ack(3000, "pend_ack");
        check("pend_done", done, 1);
        @(negedge clk);
        check("pend_queue", exp_q.size(), 0);

        // 4) hang on 0C00 -> timeout, then clean rerun
        hang_word = 16'h0C00;
        push_init(4);
        pulse_start(1, "to_start");
        i = 0;
        while (!err && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("to_err", err, 1);
        d = cyc - last_start;
        n_checks++;
        if (d < TO || d > TO + 3) begin
            n_fail++;
            $display("FAIL to_latency: got %0d cycles required %0d..%0d", d, TO, TO + 3);
        end
        @(negedge clk);
        check("to_busy", busy, 0);
        check("to_done", done, 0);
        hang_word = 16'hFFFF;
        push_init(7);
        pulse_start(1, "rerun_start");
        check("rerun_err_clr", err, 0);
        wait_idle(2000, "rerun_idle");
        check("rerun_done", done, 1);
        check("rerun_err", err, 0);

        // 5) start during WAIT ignored; async reset mid-sequence
        push_init(5);
        s0 = starts;
        pulse_start(1, "s5_start");
        wait_starts(s0 + 3, 1000, "s5_third");
        repeat (5) @(negedge clk);
        pulse_start(0, "ignored_start");
        check("ignored_busy", busy, 1);
        wait_starts(s0 + 5, 1000, "s5_fifth");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_starts", starts - s0, 5);
        check("post_rst_queue", exp_q.size(), 0);

        // 6) start and user request together: init wins, user word follows
        push_init(7);
        pulse_start(1, "s6_init");
        wait_idle(2000, "s6_idle");
        check("s6_done", done, 1);
        push_init(7);
        exp_q.push_back(16'h0479);
        @(negedge clk);
        start = 1'b1;
        req = 1'b1;
        udata = 16'h0479;
        @(negedge clk);
        start = 1'b0;
        check("tie_first_word", reg_data, 16'h1E00);
        wait_ack(3000, "tie_ack");
        @(negedge clk);
        check("tie_queue", exp_q.size(), 0);
        check("tie_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
